// File: rtl/branch_resolve_unit_if.sv
// EX-stage signal bundle for branch_resolve_unit.
// The perf-counter signals exist only when BRU_PERF_CNT_EN is defined.
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic            ex_valid;
  logic            stall;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            V, C, N, Z;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_val;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            busy;
  logic [XLEN-1:0] link_pc;
  logic            illegal_br;
`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] taken_count;
`endif

  modport master (
`ifdef BRU_PERF_CNT_EN
    input  br_count, taken_count,
`endif
    output ex_valid, stall, opcode, funct3, V, C, N, Z, PC, imm, rs1_val,
    input  redirect, redirect_pc, flush, busy, link_pc, illegal_br
  );

  modport slave (
`ifdef BRU_PERF_CNT_EN
    output br_count, taken_count,
`endif
    input  ex_valid, stall, opcode, funct3, V, C, N, Z, PC, imm, rs1_val,
    output redirect, redirect_pc, flush, busy, link_pc, illegal_br
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution with multi-cycle wrong-path flush.
// Optional performance counters enabled by defining BRU_PERF_CNT_EN.
module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  branch_resolve_unit_if.slave bus
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  if (FLUSH_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
    $error("branch_resolve_unit: FLUSH_CYCLES and CNT_W must be >= 1");
  end

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_br, is_jal, is_jalr;
  logic            cond, bad_f3, resolve, taken;
  logic [XLEN-1:0] pc_sum, jalr_sum, target;
  logic            redirect_q, illegal_q;
  logic [XLEN-1:0] redirect_pc_q, link_pc_q;

  always_comb begin
    is_br    = (bus.opcode == OP_BRANCH);
    is_jal   = (bus.opcode == OP_JAL);
    is_jalr  = (bus.opcode == OP_JALR);
    cond     = 1'b0;
    bad_f3   = 1'b0;
    case (bus.funct3)
      3'b000:  cond = bus.Z;
      3'b001:  cond = !bus.Z;
      3'b100:  cond = bus.N ^ bus.V;
      3'b101:  cond = !(bus.N ^ bus.V);
      3'b110:  cond = !bus.C;
      3'b111:  cond = bus.C;
      default: bad_f3 = 1'b1;
    endcase
    // Wrong-path instructions in FLUSH are never resolved, so redirect cannot repeat.
    resolve  = bus.ex_valid && !bus.stall && (state_q == IDLE);
    taken    = resolve && (is_jal || is_jalr || (is_br && cond));
    pc_sum   = bus.PC + bus.imm;
    jalr_sum = bus.rs1_val + bus.imm;
    target   = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc_sum;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (taken) begin
          state_d = FLUSH;
          cnt_d   = CW'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (!bus.stall) begin
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pulses clear every cycle; a stall cannot stretch them because resolve needs !stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      redirect_q    <= 1'b0;
      illegal_q     <= 1'b0;
      redirect_pc_q <= '0;
      link_pc_q     <= '0;
    end else begin
      redirect_q <= taken;
      illegal_q  <= resolve && is_br && bad_f3;
      if (taken) begin
        redirect_pc_q <= target;
        link_pc_q     <= bus.PC + XLEN'(4);
      end
    end
  end

  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.link_pc     = link_pc_q;
  assign bus.illegal_br  = illegal_q;
  assign bus.flush       = (state_q == FLUSH);
  assign bus.busy        = (state_q == FLUSH);

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] br_cnt_q, tk_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
    end else begin
      if (resolve && (is_br || is_jal || is_jalr)) br_cnt_q <= br_cnt_q + CNT_W'(1);
      if (taken)                                    tk_cnt_q <= tk_cnt_q + CNT_W'(1);
    end
  end

  assign bus.br_count    = br_cnt_q;
  assign bus.taken_count = tk_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit (FLUSH_CYCLES=2, XLEN=32, CNT_W=4).
module tb_branch_resolve_unit;
  localparam int CW = 4;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  typedef struct {
    logic        redirect;
    logic        illegal;
    logic [31:0] pc;
    logic [31:0] link;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sbq[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.XLEN(32), .CNT_W(CW)) bus ();
  branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [3:0] vcnz,
                                 input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1);
    exp_t e;
    logic v, c, n, z;
    {v, c, n, z} = vcnz;
    e.redirect = 1'b0;
    e.illegal  = 1'b0;
    e.pc       = pc + imm;
    e.link     = pc + 32'd4;
    if (op == OP_JAL) e.redirect = 1'b1;
    else if (op == OP_JALR) begin
      e.redirect = 1'b1;
      e.pc = (rs1 + imm) & 32'hFFFF_FFFE;
    end else if (op == OP_BR) begin
      case (f3)
        3'd0: e.redirect = z;
        3'd1: e.redirect = !z;
        3'd4: e.redirect = (n != v);
        3'd5: e.redirect = (n == v);
        3'd6: e.redirect = !c;
        3'd7: e.redirect = c;
        default: e.illegal = 1'b1;
      endcase
    end
    return e;
  endfunction

  // Scoreboard: every redirect or illegal pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n && (bus.redirect || bus.illegal_br)) begin
      n_checks++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_unexpected redirect=%b illegal_br=%b pc=%h required no pulse",
                 bus.redirect, bus.illegal_br, bus.redirect_pc);
      end else begin
        mon_e = sbq.pop_front();
        if (bus.redirect !== mon_e.redirect || bus.illegal_br !== mon_e.illegal ||
            (mon_e.redirect && (bus.redirect_pc !== mon_e.pc || bus.link_pc !== mon_e.link))) begin
          n_fail++;
          $display("FAIL scoreboard_pulse got rd=%b il=%b pc=%h link=%h required rd=%b il=%b pc=%h link=%h",
                   bus.redirect, bus.illegal_br, bus.redirect_pc, bus.link_pc,
                   mon_e.redirect, mon_e.illegal, mon_e.pc, mon_e.link);
        end
      end
    end
  end

  // Called at a negedge; presents one instruction for one edge and returns at the next negedge.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [3:0] vcnz,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1);
    exp_t e;
    e = model(op, f3, vcnz, pc, imm, rs1);
    if (e.redirect || e.illegal) sbq.push_back(e);
    bus.opcode = op; bus.funct3 = f3;
    {bus.V, bus.C, bus.N, bus.Z} = vcnz;
    bus.PC = pc; bus.imm = imm; bus.rs1_val = rs1;
    bus.ex_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ex_valid = 1'b0;
  endtask

  // Counts flush/redirect/busy cycles until flush drops (bounded); stalls the first stall_n cycles.
  task automatic measure(input int stall_n, output int fl, output int rd, output int bz);
    fl = 0; rd = 0; bz = 0;
    for (int i = 0; i < 50; i++) begin
      if (!bus.flush) break;
      fl += 1;
      rd += int'(bus.redirect);
      bz += int'(bus.busy);
      bus.stall = (i < stall_n);
      @(negedge clk);
    end
    bus.stall = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.redirect, bus.flush, bus.busy, bus.illegal_br} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags got %b required 0000", {bus.redirect, bus.flush, bus.busy, bus.illegal_br});
    end
    n_checks++;
    if (bus.redirect_pc !== 32'h0 || bus.link_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_pcs got %h/%h required 0/0", bus.redirect_pc, bus.link_pc);
    end
`ifdef BRU_PERF_CNT_EN
    n_checks++;
    if (bus.br_count !== '0 || bus.taken_count !== '0) begin
      n_fail++; $display("FAIL reset_counters got %h/%h required 0/0", bus.br_count, bus.taken_count);
    end
`endif
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_beq();
    int fl, rd, bz;
    issue(OP_BR, 3'b000, 4'b0001, 32'h100, 32'h20, 32'h0);
    n_checks++;
    if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h120) begin
      n_fail++; $display("FAIL beq_redirect got %b/%h required 1/00000120", bus.redirect, bus.redirect_pc);
    end
    measure(0, fl, rd, bz);
    n_checks++;
    if (fl != 2 || rd != 1 || bz != 2) begin
      n_fail++; $display("FAIL beq_flush got fl=%0d rd=%0d bz=%0d required 2/1/2", fl, rd, bz);
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.flush !== 1'b0) begin
      n_fail++; $display("FAIL beq_idle got busy=%b flush=%b required 0/0", bus.busy, bus.flush);
    end
  endtask

  task automatic test_blt_bgeu();
    int fl, rd, bz;
    issue(OP_BR, 3'b100, 4'b0010, 32'h300, 32'hFFFF_FFF0, 32'h0);
    n_checks++;
    if (bus.redirect_pc !== 32'h2F0) begin
      n_fail++; $display("FAIL blt_target got %h required 000002f0", bus.redirect_pc);
    end
    measure(0, fl, rd, bz);
    n_checks++;
    if (fl != 2 || rd != 1) begin
      n_fail++; $display("FAIL blt_flush got fl=%0d rd=%0d required 2/1", fl, rd);
    end
    issue(OP_BR, 3'b111, 4'b0000, 32'h310, 32'h40, 32'h0);
    n_checks++;
    if ({bus.redirect, bus.flush, bus.busy} !== 3'b000) begin
      n_fail++; $display("FAIL bgeu_not_taken got %b required 000", {bus.redirect, bus.flush, bus.busy});
    end
  endtask

  task automatic test_jalr();
    int fl, rd, bz;
    issue(OP_JALR, 3'b000, 4'b0000, 32'h200, 32'h4, 32'h1003);
    n_checks++;
    if (bus.redirect_pc !== 32'h1006 || bus.link_pc !== 32'h204) begin
      n_fail++; $display("FAIL jalr_pcs got %h/%h required 00001006/00000204", bus.redirect_pc, bus.link_pc);
    end
    measure(0, fl, rd, bz);
    n_checks++;
    if (fl != 2) begin
      n_fail++; $display("FAIL jalr_flush got %0d required 2", fl);
    end
  endtask

  task automatic test_stall();
    int fl, rd, bz;
    issue(OP_BR, 3'b001, 4'b0000, 32'h400, 32'h8, 32'h0);
    measure(3, fl, rd, bz);
    n_checks++;
    if (fl != 5 || rd != 1 || bz != 5) begin
      n_fail++; $display("FAIL stall_flush got fl=%0d rd=%0d bz=%0d required 5/1/5", fl, rd, bz);
    end
  endtask

  task automatic test_illegal();
    issue(OP_BR, 3'b010, 4'b0001, 32'h600, 32'h10, 32'h0);
    n_checks++;
    if ({bus.illegal_br, bus.redirect, bus.flush} !== 3'b100) begin
      n_fail++; $display("FAIL illegal_pulse got %b required 100", {bus.illegal_br, bus.redirect, bus.flush});
    end
    @(negedge clk);
    n_checks++;
    if (bus.illegal_br !== 1'b0) begin
      n_fail++; $display("FAIL illegal_one_cycle got %b required 0", bus.illegal_br);
    end
    issue(OP_BR, 3'b011, 4'b0100, 32'h604, 32'h10, 32'h0);
    n_checks++;
    if ({bus.illegal_br, bus.redirect, bus.flush} !== 3'b100) begin
      n_fail++; $display("FAIL illegal_011 got %b required 100", {bus.illegal_br, bus.redirect, bus.flush});
    end
    @(negedge clk);
  endtask

  task automatic test_other_op();
    issue(7'b0110011, 3'b000, 4'b0001, 32'h700, 32'h40, 32'h0);
    n_checks++;
    if ({bus.redirect, bus.flush, bus.illegal_br} !== 3'b000) begin
      n_fail++; $display("FAIL other_opcode got %b required 000", {bus.redirect, bus.flush, bus.illegal_br});
    end
  endtask

  task automatic test_wrap();
    int fl, rd, bz;
    issue(OP_JAL, 3'b000, 4'b0000, 32'hFFFF_FFF0, 32'h20, 32'h0);
    n_checks++;
    if (bus.redirect_pc !== 32'h10 || bus.link_pc !== 32'hFFFF_FFF4) begin
      n_fail++; $display("FAIL jal_wrap got %h/%h required 00000010/fffffff4", bus.redirect_pc, bus.link_pc);
    end
    measure(0, fl, rd, bz);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [7:0] rd_mask, fl_mask;
    e = model(OP_BR, 3'b000, 4'b0001, 32'h800, 32'h100, 32'h0);
    sbq.push_back(e);
    sbq.push_back(e);
    bus.opcode = OP_BR; bus.funct3 = 3'b000;
    {bus.V, bus.C, bus.N, bus.Z} = 4'b0001;
    bus.PC = 32'h800; bus.imm = 32'h100;
    bus.ex_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rd_mask[i] = bus.redirect;
      fl_mask[i] = bus.flush;
      if (i == 3) bus.ex_valid = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (rd_mask !== 8'b0000_1001) begin
      n_fail++; $display("FAIL b2b_redirect got %b required 00001001", rd_mask);
    end
    n_checks++;
    if (fl_mask !== 8'b0001_1011) begin
      n_fail++; $display("FAIL b2b_flush got %b required 00011011", fl_mask);
    end
  endtask

  task automatic test_reset_mid_flush();
    issue(OP_JAL, 3'b000, 4'b0000, 32'h500, 32'h10, 32'h0);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.flush, bus.busy, bus.redirect} !== 3'b000 || bus.redirect_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_flush got f/b/r=%b pc=%h required 000/0",
                         {bus.flush, bus.busy, bus.redirect}, bus.redirect_pc);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef BRU_PERF_CNT_EN
  task automatic test_perf();
    int fl, rd, bz;
    for (int k = 0; k < 17; k++) begin
      issue(OP_BR, 3'b000, 4'b0001, 32'h1000 + 32'(k * 4), 32'h40, 32'h0);
      measure(0, fl, rd, bz);
    end
    n_checks++;
    if (bus.taken_count !== CW'(17 % (1 << CW)) || bus.br_count !== CW'(17 % (1 << CW))) begin
      n_fail++; $display("FAIL perf_wrap got br=%0d taken=%0d required 1/1", bus.br_count, bus.taken_count);
    end
    issue(OP_BR, 3'b001, 4'b0001, 32'h2000, 32'h40, 32'h0);
    n_checks++;
    if (bus.br_count !== CW'(2) || bus.taken_count !== CW'(1)) begin
      n_fail++; $display("FAIL perf_not_taken got br=%0d taken=%0d required 2/1", bus.br_count, bus.taken_count);
    end
  endtask
`endif

  initial begin
    bus.ex_valid = 1'b0; bus.stall = 1'b0;
    bus.opcode = '0; bus.funct3 = '0;
    {bus.V, bus.C, bus.N, bus.Z} = 4'b0;
    bus.PC = '0; bus.imm = '0; bus.rs1_val = '0;
    test_reset();
    test_beq();
    test_blt_bgeu();
    test_jalr();
    test_stall();
    test_illegal();
    test_other_op();
    test_wrap();
    test_back_to_back();
    test_reset_mid_flush();
`ifdef BRU_PERF_CNT_EN
    test_perf();
`endif
    repeat (2) @(negedge clk);
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain got %0d pending required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
